// File: rtl/sdram_egress_sequencer_pkg.sv
// sdram_egress_sequencer_pkg: wishbone word field layout, FSM states and burst length decode
package sdram_egress_sequencer_pkg;
    localparam int ADR_LSB = 6;
    localparam int WE_BIT  = 5;
    localparam int BTE_LSB = 3;
    localparam int CTI_LSB = 0;
    localparam int DAT_LSB = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_POPA, S_DEC, S_CMD, S_WPOP, S_WDAT, S_WDLY, S_RDAT
    } state_t;

    // Linear increment bursts are re-addressed per beat by the front end, so only wraps expand.
    function automatic logic [4:0] len_decode(input logic [2:0] cti, input logic [1:0] bte);
        logic [4:0] len;
        len = 5'd1;
        if (cti == CTI_INCR)
            len = (bte == BTE_WRAP4)  ? 5'd4  :
                  (bte == BTE_WRAP8)  ? 5'd8  :
                  (bte == BTE_WRAP16) ? 5'd16 :
                  (bte == BTE_LINEAR) ? 5'd1  : 5'd1;
        if (cti == CTI_CLASSIC || cti == CTI_EOB)
            len = 5'd1;
        return len;
    endfunction
endpackage

// File: rtl/sdram_egress_sequencer_if.sv
// sdram_egress_sequencer_if: FIFO-pair, SDRAM command core and status signals of the sequencer.
interface sdram_egress_sequencer_if #(
    parameter int nr_of_wb_ports = 3,
    parameter int adr_size       = 30
);
    logic [35:0]               sdram_dat_o;
    logic [0:nr_of_wb_ports-1] sdram_fifo_empty;
    logic                      sdram_fifo_rd_adr;
    logic                      sdram_fifo_rd_data;
    logic [0:nr_of_wb_ports-1] sdram_fifo_re;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_we;
    logic [adr_size-1:0]       cmd_adr;
    logic [4:0]                cmd_len;
    logic [31:0]               wr_dat;
    logic [3:0]                wr_sel;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [31:0]               rd_dat;
    logic                      rd_valid;
    logic [31:0]               sdram_dat_i;
    logic                      sdram_fifo_wr;
    logic [0:nr_of_wb_ports-1] sdram_fifo_we;
    logic                      sdram_burst_reading;
    logic                      busy;

    modport master (
        input  sdram_dat_o, sdram_fifo_empty, cmd_ready, wr_ready, rd_dat, rd_valid,
        output sdram_fifo_rd_adr, sdram_fifo_rd_data, sdram_fifo_re, cmd_valid, cmd_we,
               cmd_adr, cmd_len, wr_dat, wr_sel, wr_valid, sdram_dat_i, sdram_fifo_wr,
               sdram_fifo_we, sdram_burst_reading, busy
    );
    modport slave (
        output sdram_dat_o, sdram_fifo_empty, cmd_ready, wr_ready, rd_dat, rd_valid,
        input  sdram_fifo_rd_adr, sdram_fifo_rd_data, sdram_fifo_re, cmd_valid, cmd_we,
               cmd_adr, cmd_len, wr_dat, wr_sel, wr_valid, sdram_dat_i, sdram_fifo_wr,
               sdram_fifo_we, sdram_burst_reading, busy
    );
endinterface

// File: rtl/sdram_egress_sequencer_rr_arbiter.sv
// sdram_egress_sequencer_rr_arbiter: N-way round-robin, first requester after the last served one wins.
module sdram_egress_sequencer_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:N-1]  i_req,
    input  logic          i_upd,
    input  logic [PW-1:0] i_upd_idx,
    output logic          o_any,
    output logic [PW-1:0] o_idx,
    output logic [0:N-1]  o_gnt
);
    logic [PW-1:0] r_last;
    logic [PW-1:0] w_j;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_last <= PW'(N - 1);
        else if (i_upd)
            r_last <= i_upd_idx;

    // Scan from farthest to nearest so the nearest requester overwrites the result last.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        o_gnt = '0;
        w_j   = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = PW'((int'(r_last) + k) % N);
            if (i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
        o_gnt[o_idx] = o_any;
    end
endmodule

// File: rtl/sdram_egress_sequencer.sv
// sdram_egress_sequencer: drains per-port egress queues into SDRAM commands and write beats,
// and steers read beats back into the owning port's ingress queue.
module sdram_egress_sequencer
    import sdram_egress_sequencer_pkg::*;
#(
    parameter int nr_of_wb_ports = 3,
    parameter int adr_size       = 30
) (
    input logic                      sdram_clk,
    input logic                      sdram_rst,
    sdram_egress_sequencer_if.master bus
);
    localparam int N  = nr_of_wb_ports;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_port, w_gnt_idx;
    logic [0:N-1]        w_gnt, w_sel;
    logic [adr_size-1:0] r_adr;
    logic                r_we;
    logic [4:0]          r_len, r_cnt;
    logic                w_any, w_q_avail, w_last_beat, w_wr_hs, w_rd_hs, w_wpop;

    sdram_egress_sequencer_rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .clk       (sdram_clk),
        .rst       (sdram_rst),
        .i_req     (~bus.sdram_fifo_empty),
        .i_upd     ((w_wr_hs || w_rd_hs) && w_last_beat),
        .i_upd_idx (r_port),
        .o_any     (w_any),
        .o_idx     (w_gnt_idx),
        .o_gnt     (w_gnt)
    );

    assign w_q_avail   = !bus.sdram_fifo_empty[r_port];
    assign w_wr_hs     = r_state == S_WDAT && bus.wr_ready;
    assign w_rd_hs     = r_state == S_RDAT && bus.rd_valid;
    assign w_last_beat = r_cnt == 5'd1;
    assign w_wpop      = w_q_avail && (r_state == S_WPOP || (w_wr_hs && !w_last_beat));

    always_comb begin
        w_sel         = '0;
        w_sel[r_port] = 1'b1;
    end

    assign bus.sdram_fifo_rd_adr   = r_state == S_IDLE && w_any && !sdram_rst;
    assign bus.sdram_fifo_rd_data  = w_wpop;
    assign bus.sdram_fifo_re       = bus.sdram_fifo_rd_adr ? w_gnt : w_wpop ? w_sel : '0;
    assign bus.cmd_valid           = r_state == S_CMD;
    assign bus.cmd_we              = r_we;
    assign bus.cmd_adr             = r_adr;
    assign bus.cmd_len             = r_len;
    assign bus.wr_valid            = r_state == S_WDAT;
    assign bus.wr_dat              = bus.wr_valid ? bus.sdram_dat_o[35:DAT_LSB] : '0;
    assign bus.wr_sel              = bus.wr_valid ? bus.sdram_dat_o[DAT_LSB-1:0] : '0;
    assign bus.sdram_fifo_wr       = w_rd_hs;
    assign bus.sdram_dat_i         = w_rd_hs ? bus.rd_dat : '0;
    assign bus.sdram_fifo_we       = w_rd_hs ? w_sel : '0;
    assign bus.sdram_burst_reading = r_state == S_RDAT;
    assign bus.busy                = r_state != S_IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_POPA : S_IDLE;
            S_POPA:  w_next = S_DEC;
            S_DEC:   w_next = S_CMD;
            S_CMD:   w_next = !bus.cmd_ready ? S_CMD : r_we ? S_WPOP : S_RDAT;
            S_WPOP:  w_next = w_q_avail ? S_WDAT : S_WPOP;
            S_WDAT:  w_next = !bus.wr_ready ? S_WDAT : w_last_beat ? S_IDLE : w_q_avail ? S_WDLY : S_WPOP;
            S_WDLY:  w_next = S_WDAT;
            S_RDAT:  w_next = (bus.rd_valid && w_last_beat) ? S_IDLE : S_RDAT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst)
        if (sdram_rst) begin
            r_state <= S_IDLE;
            r_port  <= '0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (bus.sdram_fifo_rd_adr)
                r_port <= w_gnt_idx;
            if (r_state == S_DEC) begin
                r_adr <= bus.sdram_dat_o[ADR_LSB +: adr_size];
                r_we  <= bus.sdram_dat_o[WE_BIT];
                r_len <= len_decode(bus.sdram_dat_o[CTI_LSB +: 3], bus.sdram_dat_o[BTE_LSB +: 2]);
                r_cnt <= len_decode(bus.sdram_dat_o[CTI_LSB +: 3], bus.sdram_dat_o[BTE_LSB +: 2]);
            end else if (w_wr_hs || w_rd_hs)
                r_cnt <= r_cnt - 5'd1;
        end
endmodule

// File: tb/tb_sdram_egress_sequencer.sv
// tb_sdram_egress_sequencer: directed scenarios against a queue model of the egress FIFO
// and a simple command/write/read core model.
module tb_sdram_egress_sequencer;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sdram_egress_sequencer_if #(.nr_of_wb_ports(N), .adr_size(30)) bus();
    sdram_egress_sequencer #(.nr_of_wb_ports(N), .adr_size(30)) dut (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .bus       (bus)
    );

    int vectors = 0;
    int errors  = 0;

    logic [35:0] mem [N][32];
    int          wp [N];
    int          rp [N];
    int          proto_err;
    int          cyc;
    int          n_cmd, n_wr, n_push;
    logic [29:0] cmd_adr_log [64];
    logic        cmd_we_log  [64];
    logic [4:0]  cmd_len_log [64];
    logic [31:0] wr_dat_log  [64];
    logic [3:0]  wr_sel_log  [64];
    int          wr_cyc_log  [64];

    always_comb
        for (int q = 0; q < N; q++)
            bus.sdram_fifo_empty[q] = (wp[q] == rp[q]);

    // Egress FIFO model (output register holds until the next pop) plus core-side monitors.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < N; q++)
                rp[q] <= wp[q];
            bus.sdram_dat_o <= '0;
        end else begin
            cyc <= cyc + 1;
            if (bus.sdram_fifo_rd_adr || bus.sdram_fifo_rd_data) begin
                if ((bus.sdram_fifo_rd_adr && bus.sdram_fifo_rd_data) || $countones(bus.sdram_fifo_re) != 1)
                    proto_err <= proto_err + 1;
                for (int q = 0; q < N; q++)
                    if (bus.sdram_fifo_re[q]) begin
                        if (wp[q] == rp[q])
                            proto_err <= proto_err + 1;
                        else begin
                            bus.sdram_dat_o <= mem[q][rp[q]];
                            rp[q] <= rp[q] + 1;
                        end
                    end
            end else if (bus.sdram_fifo_re != '0)
                proto_err <= proto_err + 1;
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_adr_log[n_cmd] <= bus.cmd_adr;
                cmd_we_log[n_cmd]  <= bus.cmd_we;
                cmd_len_log[n_cmd] <= bus.cmd_len;
                n_cmd <= n_cmd + 1;
            end
            if (bus.wr_valid && bus.wr_ready) begin
                wr_dat_log[n_wr] <= bus.wr_dat;
                wr_sel_log[n_wr] <= bus.wr_sel;
                wr_cyc_log[n_wr] <= cyc;
                n_wr <= n_wr + 1;
            end
            if (bus.sdram_fifo_wr)
                n_push <= n_push + 1;
        end
    end

    task automatic push(input int q, input logic [35:0] w);
        mem[q][wp[q]] = w;
        wp[q] = wp[q] + 1;
    endtask

    task automatic wait_wr(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_wr >= target) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.cmd_valid, bus.sdram_fifo_rd_adr, bus.sdram_fifo_rd_data, bus.sdram_fifo_re,
             bus.wr_valid, bus.sdram_fifo_wr, bus.sdram_fifo_we, bus.sdram_burst_reading} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b cmd_valid=%b pops=%b%b re=%b wr_valid=%b fifo_wr=%b we=%b reading=%b, want all 0",
                     bus.busy, bus.cmd_valid, bus.sdram_fifo_rd_adr, bus.sdram_fifo_rd_data, bus.sdram_fifo_re,
                     bus.wr_valid, bus.sdram_fifo_wr, bus.sdram_fifo_we, bus.sdram_burst_reading);
        end
        vectors++;
        if ({bus.cmd_adr, bus.cmd_len, bus.cmd_we, bus.wr_dat, bus.wr_sel, bus.sdram_dat_i} !== '0) begin
            errors++;
            $display("FAIL reset_data: got adr=%h len=%0d we=%b wr_dat=%h sel=%h dat_i=%h, want all 0",
                     bus.cmd_adr, bus.cmd_len, bus.cmd_we, bus.wr_dat, bus.wr_sel, bus.sdram_dat_i);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_classic_write;
        int bc = n_cmd;
        int bw = n_wr;
        bit ok;
        bus.cmd_ready = 1'b1;
        bus.wr_ready  = 1'b1;
        push(1, 36'h0000_0123);
        push(1, {32'hDEADBEEF, 4'hF});
        #1;
        vectors++;
        if (bus.sdram_fifo_rd_adr !== 1'b1 || bus.sdram_fifo_re !== 3'b010) begin
            errors++;
            $display("FAIL cw_adr_pop: got rd_adr=%b re=%b, want 1 010", bus.sdram_fifo_rd_adr, bus.sdram_fifo_re);
        end
        @(negedge clk);
        vectors++;
        if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL cw_popa: got cmd_valid=%b busy=%b, want 0 1", bus.cmd_valid, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cw_dec: got cmd_valid=%b, want 0", bus.cmd_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_we !== 1'b1 || bus.cmd_adr !== 30'h4 || bus.cmd_len !== 5'd1) begin
            errors++;
            $display("FAIL cw_cmd: got valid=%b we=%b adr=%h len=%0d, want 1 1 4 1",
                     bus.cmd_valid, bus.cmd_we, bus.cmd_adr, bus.cmd_len);
        end
        wait_wr(bw + 1, 20, ok);
        @(negedge clk);
        vectors++;
        if (!ok || n_wr != bw + 1 || n_cmd != bc + 1 || wr_dat_log[bw] !== 32'hDEADBEEF || wr_sel_log[bw] !== 4'hF) begin
            errors++;
            $display("FAIL cw_beat: got ok=%0d beats=%0d dat=%h sel=%h, want 1 %0d deadbeef f",
                     ok, n_wr - bw, wr_dat_log[bw], wr_sel_log[bw], 1);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL cw_idle: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_wrap8_read;
        int bc = n_cmd;
        int bp = n_push;
        int t = 0;
        push(0, 36'h0_0000_1012);
        while (bus.sdram_burst_reading !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 20 || n_cmd != bc + 1 || cmd_len_log[bc] !== 5'd8 || cmd_we_log[bc] !== 1'b0 || cmd_adr_log[bc] !== 30'h40) begin
            errors++;
            $display("FAIL rd8_cmd: got waited=%0d len=%0d we=%b adr=%h, want <20 8 0 40",
                     t, cmd_len_log[bc], cmd_we_log[bc], cmd_adr_log[bc]);
        end
        for (int b = 0; b < 8; b++) begin
            bus.rd_valid = 1'b1;
            bus.rd_dat   = 32'(b);
            #1;
            vectors++;
            if (bus.sdram_fifo_wr !== 1'b1 || bus.sdram_fifo_we !== 3'b100 || bus.sdram_dat_i !== 32'(b) || bus.sdram_burst_reading !== 1'b1) begin
                errors++;
                $display("FAIL rd8_beat%0d: got wr=%b we=%b dat=%h reading=%b, want 1 100 %h 1",
                         b, bus.sdram_fifo_wr, bus.sdram_fifo_we, bus.sdram_dat_i, bus.sdram_burst_reading, b);
            end
            @(negedge clk);
        end
        bus.rd_valid = 1'b0;
        #1;
        vectors++;
        if (bus.sdram_burst_reading !== 1'b0 || bus.busy !== 1'b0 || n_push != bp + 8) begin
            errors++;
            $display("FAIL rd8_end: got reading=%b busy=%b pushes=%0d, want 0 0 8", bus.sdram_burst_reading, bus.busy, n_push - bp);
        end
        bus.rd_valid = 1'b1;
        bus.rd_dat   = 32'd99;
        #1;
        vectors++;
        if (bus.sdram_fifo_wr !== 1'b0 || bus.sdram_fifo_we !== 3'b000) begin
            errors++;
            $display("FAIL rd_stray: got wr=%b we=%b, want 0 000", bus.sdram_fifo_wr, bus.sdram_fifo_we);
        end
        @(negedge clk);
        bus.rd_valid = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [29:0] ea [4] = '{30'h00, 30'h10, 30'h20, 30'h01};
        logic [31:0] ed [4] = '{32'hA0, 32'hB0, 32'hC0, 32'hA1};
        logic [3:0]  es [4] = '{4'h1, 4'h4, 4'h8, 4'h2};
        int bc, bw;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bc = n_cmd;
        bw = n_wr;
        push(0, 36'h020);
        push(0, {32'hA0, 4'h1});
        push(0, 36'h060);
        push(0, {32'hA1, 4'h2});
        push(1, 36'h420);
        push(1, {32'hB0, 4'h4});
        push(2, 36'h820);
        push(2, {32'hC0, 4'h8});
        wait_wr(bw + 4, 80, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout: got %0d writes, want 4", n_wr - bw);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cmd_adr_log[bc+i] !== ea[i] || wr_dat_log[bw+i] !== ed[i] || wr_sel_log[bw+i] !== es[i]) begin
                errors++;
                $display("FAIL rr_order%0d: got adr=%h dat=%h sel=%h, want %h %h %h",
                         i, cmd_adr_log[bc+i], wr_dat_log[bw+i], wr_sel_log[bw+i], ea[i], ed[i], es[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap4_stall;
        logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [3:0]  es [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
        int bc = n_cmd;
        int bw = n_wr;
        bit ok;
        push(2, 36'h0_0000_202A);
        push(2, {32'h11, 4'h1});
        push(2, {32'h22, 4'h3});
        wait_wr(bw + 2, 30, ok);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (!ok || bus.sdram_fifo_rd_adr !== 1'b0 || bus.sdram_fifo_rd_data !== 1'b0 || bus.wr_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL w4_stall%0d: got ok=%0d rd_adr=%b rd_data=%b wr_valid=%b busy=%b, want 1 0 0 0 1",
                         i, ok, bus.sdram_fifo_rd_adr, bus.sdram_fifo_rd_data, bus.wr_valid, bus.busy);
            end
            @(negedge clk);
        end
        push(2, {32'h33, 4'h7});
        push(2, {32'h44, 4'hF});
        wait_wr(bw + 4, 30, ok);
        vectors++;
        if (!ok || cmd_len_log[bc] !== 5'd4 || cmd_we_log[bc] !== 1'b1 || cmd_adr_log[bc] !== 30'h80) begin
            errors++;
            $display("FAIL w4_cmd: got ok=%0d len=%0d we=%b adr=%h, want 1 4 1 80", ok, cmd_len_log[bc], cmd_we_log[bc], cmd_adr_log[bc]);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (wr_dat_log[bw+i] !== ed[i] || wr_sel_log[bw+i] !== es[i]) begin
                errors++;
                $display("FAIL w4_beat%0d: got %h/%h, want %h/%h", i, wr_dat_log[bw+i], wr_sel_log[bw+i], ed[i], es[i]);
            end
        end
        vectors++;
        if (wr_cyc_log[bw+3] - wr_cyc_log[bw+2] != 2) begin
            errors++;
            $display("FAIL w4_rate: got %0d cycles between beats, want 2", wr_cyc_log[bw+3] - wr_cyc_log[bw+2]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure_reset;
        int bp;
        int t = 0;
        bus.cmd_ready = 1'b0;
        push(1, 36'h4_8D1A);
        while (bus.cmd_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_adr !== 30'h1234 || bus.cmd_len !== 5'd16 || bus.cmd_we !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b adr=%h len=%0d we=%b, want 1 1234 16 0",
                         i, bus.cmd_valid, bus.cmd_adr, bus.cmd_len, bus.cmd_we);
            end
            @(negedge clk);
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bp = n_push;
        for (int b = 0; b < 3; b++) begin
            bus.rd_valid = 1'b1;
            bus.rd_dat   = 32'hF00 + 32'(b);
            #1;
            vectors++;
            if (bus.sdram_fifo_wr !== 1'b1 || bus.sdram_fifo_we !== 3'b010 || bus.sdram_dat_i !== 32'hF00 + 32'(b)) begin
                errors++;
                $display("FAIL bp_beat%0d: got wr=%b we=%b dat=%h, want 1 010 %h",
                         b, bus.sdram_fifo_wr, bus.sdram_fifo_we, bus.sdram_dat_i, 32'hF00 + 32'(b));
            end
            @(negedge clk);
        end
        bus.rd_dat = 32'hF03;
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.sdram_burst_reading, bus.sdram_fifo_wr, bus.sdram_fifo_we, bus.sdram_dat_i, bus.cmd_valid, bus.cmd_adr} !== '0) begin
            errors++;
            $display("FAIL rst_async: got busy=%b reading=%b wr=%b we=%b dat_i=%h cmd_valid=%b adr=%h, want all 0",
                     bus.busy, bus.sdram_burst_reading, bus.sdram_fifo_wr, bus.sdram_fifo_we, bus.sdram_dat_i, bus.cmd_valid, bus.cmd_adr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.rd_valid = 1'b0;
        vectors++;
        if (n_push != bp + 3 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_push: got pushes=%0d busy=%b, want 3 0", n_push - bp, bus.busy);
        end
    endtask

    task automatic test_protocol;
        vectors++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL pop_protocol: got %0d violations, want 0", proto_err);
        end
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_dat    = '0;
        @(negedge clk);
        test_reset;
        test_classic_write;
        test_wrap8_read;
        test_round_robin;
        test_wrap4_stall;
        test_backpressure_reset;
        test_protocol;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
